keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  4x4 matrix-keypad front end. Drives the columns one at a time, samples the rows,
//  debounces press and release, and emits a one-clock press strobe with a 4-bit key
//  code. Sits directly upstream of the key buffer and feeds its press/scan_code inputs.
//  One key event yields exactly one press strobe, however long the key is held.
// PARAMETERS
//  SCAN_DIV      16    clocks each column stays driven low (row settle time); >=2
//  DEBOUNCE_CYC  1000  consecutive stable samples required for press and for release; >=2
// PORTS
//  clk        in   1  system clock; single clock domain
//  rst        in   1  asynchronous, active-high reset
//  row        in   4  keypad rows, active-low (pulled up), asynchronous to clk
//  col        out  4  keypad columns, active-low, one-hot-low while scanning
//  press      out  1  one-clock strobe: debounced key press accepted
//  scan_code  out  4  key code {row_idx[1:0], col_idx[1:0]}; valid while press=1, held after
//  key_held   out  1  high from the press strobe until the release is debounced
// BEHAVIOUR
//  Reset values: col=4'b1110, press=0, scan_code=4'h0, key_held=0, state=SCAN, all counters=0.
//  rst asserted at any time, including mid-debounce or mid-hold, returns to these values
//  immediately. No press is emitted for a key that was being debounced.
//  row passes through a 2-flop synchronizer (reset to 4'b1111). All decisions use the synced rows.
//  FSM states:
//   SCAN: col_idx is driven low for SCAN_DIV clocks. Rows are sampled only on the last clock
//     of the slot. All rows high -> col_idx+1 (3 wraps to 0) and the slot counter restarts.
//     Any row low -> latch col_idx and row_idx, then go to DEB_PRESS with col held.
//     If several rows are low, the lowest-index low row wins.
//   DEB_PRESS: counts consecutive clocks in which the latched row stays low. A clock with the
//     latched row high returns to SCAN and advances to the next column (bounce, no press).
//     When the count reaches DEBOUNCE_CYC: press=1 for exactly one clock,
//     scan_code = {row_idx, col_idx}, key_held=1, go to HOLD.
//   HOLD: col is held. Waits for all synced rows high, then goes to DEB_RELEASE.
//   DEB_RELEASE: counts consecutive clocks with all rows high. Any row low returns to HOLD.
//     When the count reaches DEBOUNCE_CYC: key_held=0, col_idx+1, go to SCAN.
//  Latency: press asserts DEBOUNCE_CYC+1 clocks after the detecting slot sample, plus
//    2 clocks of synchronizer delay from the pad.
//  A second key pressed during HOLD on another column is ignored. A second key on the same
//    column with a different row does not retrigger; only full release re-arms the scanner.
//  scan_code changes only on a press strobe. Counters saturate and never wrap.
//  Counter widths are $clog2(param)+1.
// STRUCTURE
//  keypad_defs.vh (shared include):
//   - FSM state encodings SCAN/DEB_PRESS/HOLD/DEB_RELEASE (2-bit localparams)
//   - KP_ROWS=4, KP_COLS=4
//   - key-code layout, reused by key_buffer and the display decoder
//  Sub-module key_debounce: the stable-count counter with start/match/done,
//   instantiated once and shared by DEB_PRESS and DEB_RELEASE.
//  The synchronizer is inline, not a sub-module.
// TESTING (SCAN_DIV=4, DEBOUNCE_CYC=8)
//  1 Reset, rows idle 4'b1111 for 64 clocks -> col cycles 1110,1101,1011,0111, 4 clocks each; press never 1.
//  2 Hold row=4'b1101 while col=4'b1011 for 200 clocks -> one press pulse, scan_code=4'h6, key_held=1
//    until 8 clocks after row returns to 4'b1111 (+sync).
//  3 Row bounces low 3 clocks / high 1, repeated, then stable -> no press during bounce,
//    exactly one press after 8 stable clocks.
//  4 Rows 1 and 3 both low on column 0 -> scan_code=4'h4 (lowest row wins); single press only.
//  5 Release bounce: in HOLD, toggle rows high 5 / low 1 -> key_held stays 1, no second press;
//    clean release ends HOLD.
//  6 Assert rst during DEB_PRESS (count=5) -> outputs at reset values next edge, no press;
//    scan restarts at col=4'b1110.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, matrix size and
// key-code layout (also used by the key buffer and display decoder).
package keypad_scanner_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    HOLD        = 2'd2,
    DEB_RELEASE = 2'd3
  } kp_state_e;

  typedef struct packed {
    logic [1:0] row_idx;
    logic [1:0] col_idx;
  } key_code_t;

  // Lowest-index active-low row wins when several keys share a column.
  function automatic logic [1:0] lowest_low_row(input logic [KP_ROWS-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = KP_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) begin
        idx = 2'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [KP_COLS-1:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_debounce.sv
// Saturating stable-sample counter shared by the press and release debounce
// phases; i_start restarts the count, o_done flags DEBOUNCE_CYC stable samples.
module keypad_scanner_debounce #(
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_inc,
  output logic o_done
);

  localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CW-1:0] MATCH = CW'(DEBOUNCE_CYC);
  localparam logic [CW-1:0] ONE   = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] r_count;

  // Count stable samples, holding at MATCH rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_start) begin
      r_count <= '0;
    end else if (i_inc && (r_count != MATCH)) begin
      r_count <= r_count + ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_done = (r_count == MATCH);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad front end: column scan, row synchronizer, press/release
// debounce and a single press strobe per key event.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KP_ROWS-1:0]  row,
  output logic [KP_COLS-1:0]  col,
  output logic                press,
  output logic [3:0]          scan_code,
  output logic                key_held
);

  localparam int SW = $clog2(SCAN_DIV) + 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SLOT_ONE  = {{(SW-1){1'b0}}, 1'b1};

  logic [KP_ROWS-1:0] r_row_meta;
  logic [KP_ROWS-1:0] r_row_sync;
  kp_state_e          r_state;
  logic [1:0]         r_col_idx;
  logic [1:0]         r_row_idx;
  logic [SW-1:0]      r_slot_cnt;
  logic [KP_COLS-1:0] r_col;
  logic               r_press;
  logic [3:0]         r_scan_code;
  logic               r_key_held;

  kp_state_e          w_state_nxt;
  logic [1:0]         w_col_idx_nxt;
  logic [1:0]         w_row_idx_nxt;
  logic [SW-1:0]      w_slot_nxt;
  logic               w_press_nxt;
  logic [3:0]         w_code_nxt;
  logic               w_held_nxt;
  logic               w_deb_start;
  logic               w_deb_inc;
  logic               w_deb_done;
  logic               w_all_high;
  logic               w_latched_low;
  logic               w_slot_last;
  key_code_t          w_code;

  assign w_all_high    = &r_row_sync;
  assign w_latched_low = ~r_row_sync[r_row_idx];
  assign w_slot_last   = (r_slot_cnt == SLOT_LAST);
  assign w_code        = '{row_idx: r_row_idx, col_idx: r_col_idx};

  // Two-flop synchronizer for the asynchronous, pulled-up row inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_meta <= 4'b1111;
      r_row_sync <= 4'b1111;
    end else begin
      r_row_meta <= row;
      r_row_sync <= r_row_meta;
    end
  end

  keypad_scanner_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_deb_start),
    .i_inc   (w_deb_inc),
    .o_done  (w_deb_done)
  );

  // Next-state and next-output logic; the debounce counter is held cleared
  // unless a debounce phase is actively counting stable samples.
  always_comb begin
    w_state_nxt   = r_state;
    w_col_idx_nxt = r_col_idx;
    w_row_idx_nxt = r_row_idx;
    w_slot_nxt    = '0;
    w_press_nxt   = 1'b0;
    w_code_nxt    = r_scan_code;
    w_held_nxt    = r_key_held;
    w_deb_start   = 1'b1;
    w_deb_inc     = 1'b0;
    case (r_state)
      SCAN: begin
        if (!w_slot_last) begin
          w_slot_nxt = r_slot_cnt + SLOT_ONE;
        end else if (w_all_high) begin
          w_col_idx_nxt = r_col_idx + 2'd1;
        end else begin
          w_row_idx_nxt = lowest_low_row(r_row_sync);
          w_state_nxt   = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (!w_latched_low) begin
          w_col_idx_nxt = r_col_idx + 2'd1;
          w_state_nxt   = SCAN;
        end else if (w_deb_done) begin
          w_press_nxt = 1'b1;
          w_code_nxt  = w_code;
          w_held_nxt  = 1'b1;
          w_state_nxt = HOLD;
        end else begin
          w_deb_start = 1'b0;
          w_deb_inc   = 1'b1;
        end
      end
      HOLD: begin
        if (w_all_high) begin
          w_state_nxt = DEB_RELEASE;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      DEB_RELEASE: begin
        if (!w_all_high) begin
          w_state_nxt = HOLD;
        end else if (w_deb_done) begin
          w_held_nxt    = 1'b0;
          w_col_idx_nxt = r_col_idx + 2'd1;
          w_state_nxt   = SCAN;
        end else begin
          w_deb_start = 1'b0;
          w_deb_inc   = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = SCAN;
        w_col_idx_nxt = 2'd0;
        w_held_nxt    = 1'b0;
      end
    endcase
  end

  // State, scan position and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SCAN;
      r_col_idx   <= 2'd0;
      r_row_idx   <= 2'd0;
      r_slot_cnt  <= '0;
      r_col       <= 4'b1110;
      r_press     <= 1'b0;
      r_scan_code <= 4'h0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col_idx   <= w_col_idx_nxt;
      r_row_idx   <= w_row_idx_nxt;
      r_slot_cnt  <= w_slot_nxt;
      r_col       <= col_drive(w_col_idx_nxt);
      r_press     <= w_press_nxt;
      r_scan_code <= w_code_nxt;
      r_key_held  <= w_held_nxt;
    end
  end

  assign col       = r_col;
  assign press     = r_press;
  assign scan_code = r_scan_code;
  assign key_held  = r_key_held;

endmodule
